rr_stream_arbiter_flushable: RTL

Round-robin arbiter that shares one flushable spill register among `NUM_INP` valid/ready requesters, such as TX byte sources feeding the UART transmit path. The winning beat and its source index are registered together, so the output carries no combinational path back to the requesters. A synchronous flush drops all buffered beats and arbitration lock in one cycle, for link reset and error recovery.

---
 rtl/rr_arb_pkg.sv | 9 +
 rtl/spill_register_flushable.sv | 57 +++++
 rtl/rr_stream_arbiter_flushable.sv | 118 +++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared helpers for the round-robin stream arbiter.
package rr_arb_pkg;

   // Next round-robin position after idx; the last requester wraps to 0.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx >= n - 1) ? 32'd0 : idx + 32'd1;
   endfunction

endpackage

// File: rtl/spill_register_flushable.sv
// Two-entry spill register with a synchronous flush; cuts the valid, ready and data paths.
// Bypass turns it into a combinational wire that still honours the flush.
module spill_register_flushable #(
   parameter type T      = logic,
   parameter bit  Bypass = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic flush_i,
   input  logic valid_i,
   output logic ready_o,
   input  T     data_i,
   output logic valid_o,
   input  logic ready_i,
   output T     data_o
);

   if (Bypass) begin : gen_bypass
      assign valid_o = valid_i && !flush_i;
      assign ready_o = ready_i && !flush_i;
      assign data_o  = data_i;
   end else begin : gen_spill
      // Entry a takes new beats; entry b holds the older beat while the output stalls.
      T     a_data_q, b_data_q;
      logic a_full_q, b_full_q;
      logic a_full_d, b_full_d;
      logic a_fill, a_drain, b_fill, b_drain;

      assign a_fill   = valid_i && ready_o && !flush_i;
      assign a_drain  = (a_full_q && !b_full_q) || flush_i;
      assign b_fill   = a_full_q && !b_full_q && !ready_i && !flush_i;
      assign b_drain  = (b_full_q && ready_i) || flush_i;

      assign a_full_d = a_fill || (a_full_q && !a_drain);
      assign b_full_d = b_fill || (b_full_q && !b_drain);

      // NOTE: payload registers are reset too, so data_o reads zero while reset is held.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            a_full_q <= 1'b0;
            b_full_q <= 1'b0;
            a_data_q <= '0;
            b_data_q <= '0;
         end else begin
            a_full_q <= a_full_d;
            b_full_q <= b_full_d;
            if (a_fill) a_data_q <= data_i;
            if (b_fill) b_data_q <= a_data_q;
         end
      end

      assign ready_o = !a_full_q || !b_full_q;
      assign valid_o = a_full_q || b_full_q;
      assign data_o  = b_full_q ? b_data_q : a_data_q;
   end

endmodule

// File: rtl/rr_stream_arbiter_flushable.sv
// Round-robin arbiter of NUM_INP valid/ready requesters into one flushable spill register.
// The grant locks onto a stalled winner until it is accepted.
module rr_stream_arbiter_flushable
   import rr_arb_pkg::*;
#(
   parameter int unsigned  NUM_INP    = 4,
   parameter int unsigned  DATA_WIDTH = 8,
   parameter bit           BYPASS     = 1'b0,
   localparam int unsigned IDX_WIDTH  = $clog2(NUM_INP)
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                flush_i,
   input  logic [NUM_INP-1:0]                  inp_valid_i,
   output logic [NUM_INP-1:0]                  inp_ready_o,
   input  logic [NUM_INP-1:0][DATA_WIDTH-1:0]  inp_data_i,
   output logic                                oup_valid_o,
   input  logic                                oup_ready_i,
   output logic [DATA_WIDTH-1:0]               oup_data_o,
   output logic [IDX_WIDTH-1:0]                oup_idx_o
);

   typedef struct packed {
      logic [IDX_WIDTH-1:0]  idx;
      logic [DATA_WIDTH-1:0] data;
   } beat_t;

   function automatic logic [IDX_WIDTH-1:0] wrap_add(input int unsigned a, input int unsigned b);
      return IDX_WIDTH'((a + b >= NUM_INP) ? a + b - NUM_INP : a + b);
   endfunction

   logic [IDX_WIDTH-1:0] rr_q, rr_d;
   logic                 lock_q, lock_d;
   logic [IDX_WIDTH-1:0] lock_idx_q, lock_idx_d;

   logic [NUM_INP-1:0]   rot_valid;
   logic [IDX_WIDTH-1:0] rot_pos, arb_idx, win_idx;
   logic                 arb_found, win_valid, spill_valid, spill_ready, grant;
   beat_t                beat_in, beat_out;

   // Rotate so rr_q sits at bit 0, take the lowest set bit, then rotate back.
   always_comb begin
      rot_valid = '0;
      rot_pos   = '0;
      arb_found = 1'b0;
      for (int unsigned k = 0; k < NUM_INP; k++) begin
         rot_valid[k] = inp_valid_i[wrap_add(k, 32'(rr_q))];
      end
      for (int k = NUM_INP - 1; k >= 0; k--) begin
         if (rot_valid[k]) begin
            rot_pos   = IDX_WIDTH'(k);
            arb_found = 1'b1;
         end
      end
      arb_idx = wrap_add(32'(rot_pos), 32'(rr_q));
   end

   assign win_idx     = lock_q ? lock_idx_q : arb_idx;
   assign win_valid   = lock_q ? inp_valid_i[lock_idx_q] : arb_found;
   // NOTE: rst_ni gates the grant so no requester sees ready while reset is held.
   assign spill_valid = win_valid && rst_ni;
   assign grant       = spill_valid && spill_ready && !flush_i;

   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      inp_ready_o          = '0;
      inp_ready_o[win_idx] = grant;
   end

   always_comb begin
      rr_d       = rr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (flush_i) begin
         lock_d = 1'b0;
      end else if (grant) begin
         rr_d   = IDX_WIDTH'(rr_next(32'(win_idx), NUM_INP));
         lock_d = 1'b0;
      end else if (win_valid) begin
         lock_d     = 1'b1;
         lock_idx_d = win_idx;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q       <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         rr_q       <= rr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   assign beat_in.idx  = win_idx;
   assign beat_in.data = inp_data_i[win_idx];

   spill_register_flushable #(
      .T      (beat_t),
      .Bypass (BYPASS)
   ) i_spill (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .valid_i (spill_valid),
      .ready_o (spill_ready),
      .data_i  (beat_in),
      .valid_o (oup_valid_o),
      .ready_i (oup_ready_i),
      .data_o  (beat_out)
   );

   assign oup_data_o = beat_out.data;
   assign oup_idx_o  = beat_out.idx;

endmodule
